// File: rtl/sobel_edge_if.sv
// Pixel stream bundle for sobel_edge: smoothed pixels in, gradient magnitude and edge flag out.
// frame_start exists only when SOBEL_FRAME_SYNC_EN is defined.
interface sobel_edge_if;
    logic [7:0] data_in;
    logic       data_valid;
`ifdef SOBEL_FRAME_SYNC_EN
    logic       frame_start;
`endif
    logic [7:0] data_out;
    logic       data_out_valid;
    logic       edge_out;

`ifdef SOBEL_FRAME_SYNC_EN
    modport master (output data_in, data_valid, frame_start,
                    input  data_out, data_out_valid, edge_out);
    modport slave  (input  data_in, data_valid, frame_start,
                    output data_out, data_out_valid, edge_out);
`else
    modport master (output data_in, data_valid,
                    input  data_out, data_out_valid, edge_out);
    modport slave  (input  data_in, data_valid,
                    output data_out, data_out_valid, edge_out);
`endif
endinterface

// File: rtl/sobel_edge.sv
// Streaming 3x3 Sobel edge detector: two line buffers, a 3x3 window and a 3-stage output pipeline.
// Optional SOBEL_FRAME_SYNC_EN adds frame_start to restart row/column tracking in-stream.
module sobel_edge #(
    parameter int MAX_WIDTH = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    sobel_edge_if.slave px,
    input  logic [11:0] img_width,
    input  logic [7:0]  threshold
);
    localparam int AW    = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;
    localparam int DEPTH = 2 ** AW;

    logic [7:0]  line_buf1 [DEPTH];
    logic [7:0]  line_buf2 [DEPTH];

    logic [11:0] col_count;
    logic [1:0]  row_count;
    logic [7:0]  win [9];

    logic        frame_restart;
    logic [11:0] cur_col;
    logic [1:0]  cur_row;
    logic        last_col;
    logic        complete;
    logic [AW-1:0] addr;
    logic [7:0]  top_pix;
    logic [7:0]  mid_pix;

    // Beat decode: a frame_start beat is seen as col 0 of row 0 before any other decision.
    // NOTE: every always_comb output gets a default first so no latch can be inferred.
    always_comb begin
        frame_restart = 1'b0;
`ifdef SOBEL_FRAME_SYNC_EN
        frame_restart = px.frame_start;
`endif
        cur_col  = frame_restart ? 12'd0 : col_count;
        cur_row  = frame_restart ? 2'd0  : row_count;
        last_col = (img_width <= 12'd1) || (cur_col >= img_width - 12'd1);
        complete = px.data_valid && (cur_row == 2'd2) && (cur_col >= 12'd2)
                   && (img_width >= 12'd3);
        addr     = cur_col[AW-1:0];
        top_pix  = line_buf2[addr];
        mid_pix  = line_buf1[addr];
    end

    // NOTE: sequential state is assigned with <= so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_count <= '0;
            row_count <= '0;
        end else if (px.data_valid) begin
            if (last_col) begin
                col_count <= '0;
                row_count <= (cur_row == 2'd2) ? 2'd2 : cur_row + 2'd1;
            end else begin
                col_count <= cur_col + 12'd1;
                row_count <= cur_row;
            end
        end
    end

    // NOTE: line-buffer RAM has no reset; stale lines are masked by row_count.
    always_ff @(posedge clk) begin
        if (px.data_valid) begin
            line_buf2[addr] <= line_buf1[addr];
            line_buf1[addr] <= px.data_in;
        end
    end

    logic v0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 9; i++) win[i] <= '0;
            v0 <= 1'b0;
        end else begin
            v0 <= complete;
            if (px.data_valid) begin
                win[0] <= win[1];  win[1] <= win[2];  win[2] <= top_pix;
                win[3] <= win[4];  win[4] <= win[5];  win[5] <= mid_pix;
                win[6] <= win[7];  win[7] <= win[8];  win[8] <= px.data_in;
            end
        end
    end

    // S1: gradient kernels; operands widened to 11 bits so the difference wraps to a correct signed value.
    logic [10:0]        gx_pos, gx_neg, gy_pos, gy_neg;
    logic signed [10:0] gx_next, gy_next;

    always_comb begin
        gx_pos  = {3'b0, win[2]} + {2'b0, win[5], 1'b0} + {3'b0, win[8]};
        gx_neg  = {3'b0, win[0]} + {2'b0, win[3], 1'b0} + {3'b0, win[6]};
        gy_pos  = {3'b0, win[6]} + {2'b0, win[7], 1'b0} + {3'b0, win[8]};
        gy_neg  = {3'b0, win[0]} + {2'b0, win[1], 1'b0} + {3'b0, win[2]};
        gx_next = signed'(gx_pos - gx_neg);
        gy_next = signed'(gy_pos - gy_neg);
    end

    logic signed [10:0] gx, gy;
    logic               v1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gx <= '0;
            gy <= '0;
            v1 <= 1'b0;
        end else begin
            gx <= gx_next;
            gy <= gy_next;
            v1 <= v0;
        end
    end

    // S2: L1 magnitude, max 2040, clipped to the 8-bit output range.
    logic [10:0] abs_x, abs_y, mag;
    logic [7:0]  sat_next;

    always_comb begin
        abs_x    = gx[10] ? 11'(-gx) : 11'(gx);
        abs_y    = gy[10] ? 11'(-gy) : 11'(gy);
        mag      = abs_x + abs_y;
        sat_next = (mag > 11'd255) ? 8'd255 : mag[7:0];
    end

    logic [7:0] sat_mag;
    logic       v2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_mag <= '0;
            v2      <= 1'b0;
        end else begin
            sat_mag <= sat_next;
            v2      <= v1;
        end
    end

    // S3: outputs hold their last value between valid pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            px.data_out       <= '0;
            px.data_out_valid <= 1'b0;
            px.edge_out       <= 1'b0;
        end else begin
            px.data_out_valid <= v2;
            if (v2) begin
                px.data_out <= sat_mag;
                px.edge_out <= (sat_mag >= threshold);
            end
        end
    end

endmodule

// File: tb/tb_sobel_edge.sv
// Self-checking bench for sobel_edge: per-window Sobel reference computed from the full image array.
// Exercises the SOBEL_FRAME_SYNC_EN restart when that macro is defined.
module tb_sobel_edge;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [11:0] img_width = 12'd8;
    logic [7:0]  threshold = 8'd10;

    sobel_edge_if sif();

    sobel_edge #(.MAX_WIDTH(64)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .px        (sif),
        .img_width (img_width),
        .threshold (threshold)
    );

    always #5 clk = ~clk;

    typedef struct {
        int mag;
        int edg;
        int due;
    } exp_t;

    exp_t       expq [$];
    logic [7:0] pix [8][16];
    int         cyc = 0;
    int         n_cmp = 0;
    int         n_err = 0;
    int         n_out = 0;
    int         last_mag = 0;
    int         first_out_cyc = -1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int got, input int want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    // Sobel over the 3x3 neighbourhood whose bottom-right pixel is (r,c).
    function automatic exp_t model(input int r, input int c, input int due);
        exp_t e;
        int gx, gy, m;
        gx = (int'(pix[r-2][c]) + 2*int'(pix[r-1][c]) + int'(pix[r][c]))
           - (int'(pix[r-2][c-2]) + 2*int'(pix[r-1][c-2]) + int'(pix[r][c-2]));
        gy = (int'(pix[r][c-2]) + 2*int'(pix[r][c-1]) + int'(pix[r][c]))
           - (int'(pix[r-2][c-2]) + 2*int'(pix[r-2][c-1]) + int'(pix[r-2][c]));
        m = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
        if (m > 255) m = 255;
        e.mag = m;
        e.edg = (m >= int'(threshold)) ? 1 : 0;
        e.due = due;
        return e;
    endfunction

    always @(negedge clk) begin
        if (rst_n && sif.data_out_valid) begin
            n_out++;
            if (first_out_cyc < 0) first_out_cyc = cyc;
            if (expq.size() == 0) begin
                check("spurious_out", 1, 0);
            end else begin
                exp_t e;
                e = expq.pop_front();
                check("data_out", int'(sif.data_out), e.mag);
                check("edge_out", int'(sif.edge_out), e.edg);
                check("latency", cyc, e.due);
            end
            last_mag = int'(sif.data_out);
        end
    end

    // Streams rows x w pixels from pix; gap_mode 0=none, 1=alternate, 2=random; stops before beat stop_at.
    task automatic send_frame(input int w, input int rows, input int gap_mode,
                              input bit fs, input int stop_at);
        int idx = 0;
        int gaps;
        img_width = 12'(w);
        for (int r = 0; r < rows; r++) begin
            for (int c = 0; c < w; c++) begin
                if (idx == stop_at) return;
                sif.data_in    = pix[r][c];
                sif.data_valid = 1'b1;
`ifdef SOBEL_FRAME_SYNC_EN
                sif.frame_start = fs && (idx == 0);
`endif
                if (r >= 2 && c >= 2 && w >= 3) expq.push_back(model(r, c, cyc + 4));
                @(posedge clk); #1;
                sif.data_valid = 1'b0;
`ifdef SOBEL_FRAME_SYNC_EN
                sif.frame_start = 1'b0;
`endif
                gaps = (gap_mode == 1) ? 1 : (gap_mode == 2) ? int'($urandom_range(0, 2)) : 0;
                repeat (gaps) begin @(posedge clk); #1; end
                idx++;
            end
        end
        if (fs) idx = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        expq.delete();
        last_mag = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic drain(input string tag);
        repeat (8) @(posedge clk);
        #1;
        check({tag, "_pending"}, expq.size(), 0);
        check({tag, "_hold"}, int'(sif.data_out), last_mag);
    endtask

    task automatic fill_flat(input int v);
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 16; c++) pix[r][c] = 8'(v);
    endtask

    task automatic fill_step();
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 16; c++) pix[r][c] = (c >= 4) ? 8'd255 : 8'd0;
    endtask

    task automatic fill_random(input int hi);
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 16; c++) pix[r][c] = 8'($urandom_range(0, hi));
    endtask

    initial begin
        int base, w, rows, acc0;
        sif.data_in    = '0;
        sif.data_valid = 1'b0;
`ifdef SOBEL_FRAME_SYNC_EN
        sif.frame_start = 1'b0;
`endif
        #2;
        check("rst_data_out", int'(sif.data_out), 0);
        check("rst_valid", int'(sif.data_out_valid), 0);
        check("rst_edge", int'(sif.edge_out), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Flat image: no gradient anywhere.
        fill_flat(100);
        threshold = 8'd10;
        base = n_out;
        send_frame(8, 4, 0, 1'b0, -1);
        drain("flat");
        check("flat_count", n_out - base, 12);

        // Vertical step, back to back, then with alternating bubbles.
        do_reset();
        fill_step();
        threshold = 8'd128;
        base = n_out;
        send_frame(8, 4, 0, 1'b0, -1);
        drain("step");
        check("step_count", n_out - base, 12);

        do_reset();
        base = n_out;
        send_frame(8, 4, 1, 1'b0, -1);
        drain("step_gap");
        check("step_gap_count", n_out - base, 12);

        // Threshold 0 makes every window an edge.
        do_reset();
        fill_flat(100);
        threshold = 8'd0;
        base = n_out;
        send_frame(8, 4, 0, 1'b0, -1);
        drain("thr0");
        check("thr0_count", n_out - base, 12);

        // Minimum width, then an illegal width that must emit nothing.
        do_reset();
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 16; c++) pix[r][c] = 8'(r * 20 + c * 7);
        threshold = 8'd50;
        base = n_out;
        send_frame(3, 5, 0, 1'b0, -1);
        drain("w3");
        check("w3_count", n_out - base, 3);
        base = n_out;
        send_frame(2, 5, 0, 1'b0, -1);
        drain("w2");
        check("w2_count", n_out - base, 0);

        // Random images, widths, thresholds and bubbles.
        for (int it = 0; it < 8; it++) begin
            do_reset();
            w    = int'($urandom_range(3, 16));
            rows = int'($urandom_range(3, 8));
            fill_random((it % 2 == 0) ? 40 : 255);
            threshold = 8'($urandom_range(0, 255));
            base = n_out;
            send_frame(w, rows, 2, 1'b0, -1);
            drain("rand");
            check("rand_count", n_out - base, (w - 2) * (rows - 2));
        end

        // Reset mid-frame after row 2 col 4, with results still in flight.
        do_reset();
        fill_random(255);
        threshold = 8'd100;
        send_frame(8, 4, 0, 1'b0, 21);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_data_out", int'(sif.data_out), 0);
        check("midrst_valid", int'(sif.data_out_valid), 0);
        check("midrst_edge", int'(sif.edge_out), 0);
        expq.delete();
        last_mag = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        first_out_cyc = -1;
        acc0 = cyc + 1;
        base = n_out;
        send_frame(8, 4, 0, 1'b0, -1);
        drain("restart");
        check("restart_count", n_out - base, 12);
        check("restart_first_lat", first_out_cyc - acc0, 2 * 8 + 2 + 3);

`ifdef SOBEL_FRAME_SYNC_EN
        // frame_start mid-stream: in-flight windows finish, then a fresh frame begins.
        do_reset();
        fill_random(255);
        base = n_out;
        send_frame(8, 4, 0, 1'b0, 21);
        first_out_cyc = -1;
        send_frame(8, 4, 0, 1'b1, -1);
        drain("fsync");
        check("fsync_count", n_out - base, 3 + 12);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
